// File: rtl/cmp_sort_ctrl_pkg.sv
// rtl/cmp_sort_ctrl_pkg.sv - shared state encoding and default sizes for the burst sorter
package cmp_sort_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_W      = 4;
  localparam int DEF_N      = 8;
  localparam int SWAP_CNT_W = 8;

endpackage

// File: rtl/cmp_sort_ctrl_cmp.sv
// rtl/cmp_sort_ctrl_cmp.sv - signed magnitude comparator shared by the sort controller
module cmp_sort_ctrl_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         altb,
  output logic         aeqb,
  output logic         agtb
);

  // two's-complement compare; exactly one flag is high at a time
  always_comb begin
    altb = ($signed(a) <  $signed(b));
    aeqb = (a == b);
    agtb = ($signed(a) >  $signed(b));
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - load/bubble-sort/drain controller; SORT_EARLY_EXIT_EN ends sorting after a swap-free pass
module cmp_sort_ctrl
  import cmp_sort_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  busy,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  state_t        state, state_nxt;
  logic [W-1:0]  sbuf [N];
  logic [IW-1:0] wr_idx, rd_idx, idx, pass;
  logic [IW-1:0] idx_n;
  logic          altb, aeqb, agtb;
  logic          last_cmp, last_pass, pass_clean, sort_done;

  assign idx_n     = idx + 1'b1;
  assign last_cmp  = (idx  == IW'(N - 2));
  assign last_pass = (pass == IW'(N - 2));

`ifdef SORT_EARLY_EXIT_EN
  logic swapped;
  // a pass is clean when neither an earlier compare nor this final one swapped
  assign pass_clean = !(swapped || agtb);
`else
  assign pass_clean = 1'b0;
`endif

  assign sort_done = last_cmp && (last_pass || pass_clean);

  cmp_sort_ctrl_cmp #(.W(W)) u_cmp (
    .a    (sbuf[idx]),
    .b    (sbuf[idx_n]),
    .altb (altb),
    .aeqb (aeqb),
    .agtb (agtb)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == IW'(N - 1))) state_nxt = ST_SORT;
      end
      ST_SORT: begin
        busy = 1'b1;
        if (sort_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sbuf[rd_idx];
        if (out_ready && (rd_idx == IW'(N - 1))) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // buffer, indices and swap counter; aeqb/altb leave the pair untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) sbuf[k] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      idx      <= '0;
      pass     <= '0;
      swap_cnt <= '0;
`ifdef SORT_EARLY_EXIT_EN
      swapped  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            sbuf[wr_idx] <= in_data;
            if (wr_idx == IW'(N - 1)) begin
              wr_idx   <= '0;
              idx      <= '0;
              pass     <= '0;
              swap_cnt <= '0;
`ifdef SORT_EARLY_EXIT_EN
              swapped  <= 1'b0;
`endif
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        ST_SORT: begin
          if (agtb) begin
            sbuf[idx]   <= sbuf[idx_n];
            sbuf[idx_n] <= sbuf[idx];
            if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= 1'b1;
`endif
          end
          if (last_cmp) begin
            idx  <= '0;
            pass <= pass + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
            if (sort_done) rd_idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rd_idx == IW'(N - 1)) begin
              rd_idx <= '0;
              wr_idx <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - directed table-driven bench for cmp_sort_ctrl
module tb_cmp_sort_ctrl;

  localparam int W = 4;
  localparam int N = 8;
  localparam int FULL_CYC = (N - 1) * (N - 1);
`ifdef SORT_EARLY_EXIT_EN
  localparam int SORTED_CYC = N - 1;
  localparam int UNSORTED_CYC = -1;
`else
  localparam int SORTED_CYC = FULL_CYC;
  localparam int UNSORTED_CYC = FULL_CYC;
`endif
  localparam int NV = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
  logic [7:0]   swap_cnt;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int din  [N];
    int dout [N];
    int swaps;
    int sort_cyc;
    bit bp;
    bit junk;
  } vec_t;

  vec_t vt [NV];

  cmp_sort_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_burst(input int v, output bit ok);
    logic [31:0] w;
    ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) ok = 1'b0;
      w        = vt[v].din[k];
      in_valid = 1'b1;
      in_data  = w[W-1:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int v);
    bit ok;
    int n;
    load_burst(v, ok);
    chk($sformatf("v%0d in_ready during load", v), int'(ok), 1);
    chk($sformatf("v%0d in_ready after last word", v), int'(in_ready), 0);
    chk($sformatf("v%0d busy in sort", v), int'(busy), 1);
    n = 0;
    while (!out_valid && n < 200) begin
      if (vt[v].junk) begin
        in_valid = 1'b1;
        in_data  = 4'h5;
        out_ready = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk($sformatf("v%0d out_valid reached", v), int'(out_valid), 1);
    if (vt[v].sort_cyc >= 0)
      chk($sformatf("v%0d sort cycles", v), n, vt[v].sort_cyc);
    chk($sformatf("v%0d swap_cnt", v), int'(swap_cnt), vt[v].swaps);
    for (int k = 0; k < N; k++) begin
      if (vt[v].bp && k == 3) begin
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          chk($sformatf("v%0d bp out_valid", v), int'(out_valid), 1);
          chk($sformatf("v%0d bp out_data", v), int'($signed(out_data)), vt[v].dout[k]);
          chk($sformatf("v%0d bp in_ready", v), int'(in_ready), 0);
          @(negedge clk);
        end
      end
      chk($sformatf("v%0d out_valid[%0d]", v, k), int'(out_valid), 1);
      chk($sformatf("v%0d out_data[%0d]", v, k), int'($signed(out_data)), vt[v].dout[k]);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk($sformatf("v%0d in_ready after drain", v), int'(in_ready), 1);
    chk($sformatf("v%0d out_valid after drain", v), int'(out_valid), 0);
    chk($sformatf("v%0d busy after drain", v), int'(busy), 0);
    chk($sformatf("v%0d swap_cnt held", v), int'(swap_cnt), vt[v].swaps);
  endtask

  initial begin
    vt[0].din  = '{7, 6, 5, 4, 3, 2, 1, 0};
    vt[0].dout = '{0, 1, 2, 3, 4, 5, 6, 7};
    vt[0].swaps = 28; vt[0].sort_cyc = UNSORTED_CYC; vt[0].bp = 0; vt[0].junk = 0;

    vt[1].din  = '{0, -7, 1, -6, 2, -2, 3, -8};
    vt[1].dout = '{-8, -7, -6, -2, 0, 1, 2, 3};
    vt[1].swaps = 13; vt[1].sort_cyc = UNSORTED_CYC; vt[1].bp = 1; vt[1].junk = 1;

    vt[2].din  = '{3, 3, 4, 4, -1, -1, 0, 0};
    vt[2].dout = '{-1, -1, 0, 0, 3, 3, 4, 4};
    vt[2].swaps = 16; vt[2].sort_cyc = UNSORTED_CYC; vt[2].bp = 0; vt[2].junk = 0;

    vt[3].din  = '{-8, -7, -6, -5, -4, -3, -2, -1};
    vt[3].dout = '{-8, -7, -6, -5, -4, -3, -2, -1};
    vt[3].swaps = 0; vt[3].sort_cyc = SORTED_CYC; vt[3].bp = 0; vt[3].junk = 0;

    vt[4].din  = '{5, 5, 5, 5, 5, 5, 5, 5};
    vt[4].dout = '{5, 5, 5, 5, 5, 5, 5, 5};
    vt[4].swaps = 0; vt[4].sort_cyc = SORTED_CYC; vt[4].bp = 0; vt[4].junk = 0;

    vt[5].din  = '{7, -8, 7, -8, 7, -8, 7, -8};
    vt[5].dout = '{-8, -8, -8, -8, 7, 7, 7, 7};
    vt[5].swaps = 10; vt[5].sort_cyc = UNSORTED_CYC; vt[5].bp = 1; vt[5].junk = 0;

    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset swap_cnt", int'(swap_cnt), 0);
    chk("reset out_data", int'(out_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) run_vec(v);

    begin : mid_sort_reset
      bit ok;
      load_burst(0, ok);
      chk("rst load in_ready", int'(ok), 1);
      repeat (19) @(negedge clk);
      chk("rst pre busy", int'(busy), 1);
      chk("rst pre swap_cnt nonzero", int'(swap_cnt != 0), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst async in_ready", int'(in_ready), 1);
      chk("rst async busy", int'(busy), 0);
      chk("rst async out_valid", int'(out_valid), 0);
      chk("rst async swap_cnt", int'(swap_cnt), 0);
      chk("rst async out_data", int'(out_data), 0);
      @(negedge clk);
      rst = 1'b0;
      run_vec(1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
